dm_access_seq: RTL and testbench
================================

# dm_access_seq

Data-memory access sequencer between the CPU memory stage and a word-only, single-port synchronous data memory. It accepts one load/store request at a time (word or byte granularity), aligns the address, and performs byte stores as a read-modify-write. It extracts load bytes with the same lane rules as the byte access controller (BAC) and returns a single-cycle response. It is the sequencing layer around BAC-style alignment/merge logic, which it contains internally.

## Interface

- No parameters (32-bit address/data fixed).
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, request accepted on clk edge when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_byte  in  1  1 = byte access, 0 = word access
- req_addr  in  32  byte address
- req_wdata  in  32  store data, byte store uses bits [7:0]
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result (byte zero-extended), 0 for stores/errors
- resp_err  out  1  misaligned word access, valid with resp_valid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  word written
- mem_rdata  in  32  read data, valid the cycle after mem_en && !mem_we

## Operation

- States: IDLE, RD, RCAP, WR, RESP.
- IDLE: req_ready=1. On accept, latch we/byte/addr/wdata. Next state:
  - word access with addr[1:0]!=0 goes to RESP with err=1. No memory access.
  - word store goes to WR.
  - load or byte store goes to RD.
- RD: mem_en=1, mem_we=0, mem_addr=aligned. Next state is RCAP.
- RCAP: capture mem_rdata into read buffer.
  - Load goes to RESP. Result is the full word, or byte lane addr[1:0] (lane 0=[7:0] … lane 3=[31:24]) zero-extended.
  - Byte store goes to WR. Merge is buffer with lane addr[1:0] replaced by wdata[7:0].
- WR: mem_en=1, mem_we=1, mem_wdata = wdata (word) or merged word (byte). Next state is RESP.
- RESP: resp_valid=1 and resp_rdata/resp_err are presented. Next state is IDLE.
- Requests are ignored when req_ready=0. There is no queueing.
- mem_en=0 in IDLE and RESP. mem_wdata=0 and mem_we=0 whenever not in WR.
- resp_rdata/resp_err are registered and hold their last value between responses.

## Timing

- Cycle 0 = accept edge. Latency from accept to the resp_valid cycle:
  - word store: WR in cycle 1, resp in cycle 2.
  - load: RD 1, RCAP 2, resp 3.
  - byte store: RD 1, RCAP 2, WR 3, resp 4.
  - misaligned word: resp in cycle 1.
- req_ready rises in the cycle after RESP. Back-to-back accept is possible at that edge.
- Reset (on any edge, any state): state=IDLE, req_ready=1 in the following cycle, resp_valid=0, resp_rdata=0, resp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, buffers=0.
- Reset mid-operation abandons the request. No pending WR is issued, and no response is issued for it.
- Reset held with req_valid=1 does not accept the request.
- mem_rdata is sampled only in RCAP. Values on other cycles are don't-care.
- Byte access ignores addr[1:0] for alignment: it is never an error.

## Test plan

- Word store/load: store addr 0x40, data 0x1234_5678. Expect mem write word 0x40 in cycle 1, resp cycle 2 err=0. Load 0x40 returns 0x1234_5678 at cycle 3.
- Byte store RMW: mem[0x40]=0x7890_1234, store byte addr 0x41, wdata 0x1234_5678. Expect read 0x40 cycle 1, write 0x7890_7834 cycle 3, resp cycle 4.
- Byte load all lanes: mem[0x40]=0x7890_1234, load byte 0x40/0x41/0x42/0x43. Expect 0x34/0x12/0x90/0x78, each zero-extended, with no write.
- Misaligned word: load 0x42 and store 0x41. Expect resp cycle 1, err=1, rdata=0, mem_en never asserted.
- Busy/back-to-back: hold req_valid during a byte store. Expect req_ready=0 in cycles 1–4, second request accepted at the edge after RESP, and the second request's address changes ignored until then.
- Reset mid-op: assert reset while in RCAP of a byte store. Expect no write and no resp. Next cycle req_ready=1 and all outputs 0. A subsequent word load completes normally.

Source files
------------

// File: rtl/dm_access_seq.sv
// dm_access_seq: data-memory access sequencer between the CPU memory stage and a
// word-only, single-port synchronous data memory. It handles one request at a time.
// Word accesses must be aligned. Misaligned word accesses return an error without
// touching memory. Byte stores are done as a read-modify-write. Byte loads return the
// selected lane zero-extended. Every output is registered.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   req_*             request channel (valid/ready handshake; we, byte, addr, wdata)
//   resp_*            single-cycle response pulse with read data and error flag
//   mem_*             synchronous memory port; read data arrives the cycle after a read

module dm_access_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {StIdle, StRd, StRcap, StWr, StResp} state_e;

    state_e     state_q;
    logic       we_q;
    logic       byte_q;
    logic [1:0] lane_q;
    logic [7:0] wbyte_q;

    // Lane 0 is bits [7:0] and lane 3 is bits [31:24].
    function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // Outputs are set on the edge that enters a state, so they are valid for that state.
    // The read word is captured directly into resp_rdata (loads) or mem_wdata (byte
    // stores), and those registers act as the read buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            lane_q     <= 2'd0;
            wbyte_q    <= 8'h0;
        end else begin
            // These outputs are pulses. mem_addr and the resp data hold their values.
            resp_valid <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= 32'h0;

            case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        byte_q    <= req_byte;
                        lane_q    <= req_addr[1:0];
                        wbyte_q   <= req_wdata[7:0];
                        if (!req_byte && (req_addr[1:0] != 2'b00)) begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                            resp_err   <= 1'b1;
                        end else if (req_we && !req_byte) begin
                            state_q   <= StWr;
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_wdata;
                        end else begin
                            state_q  <= StRd;
                            mem_en   <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end
                    end
                end

                StRd: begin
                    state_q <= StRcap;
                end

                StRcap: begin
                    if (!we_q) begin
                        state_q    <= StResp;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= byte_q ? {24'h0, lane_sel(mem_rdata, lane_q)}
                                             : mem_rdata;
                    end else begin
                        // Only byte stores reach RCAP with we set.
                        state_q   <= StWr;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= lane_merge(mem_rdata, lane_q, wbyte_q);
                    end
                end

                StWr: begin
                    state_q    <= StResp;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                end

                StResp: begin
                    state_q   <= StIdle;
                    req_ready <= 1'b1;
                end

                default: begin
                    state_q   <= StIdle;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_seq.sv
module tb_dm_access_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dm_access_seq dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous memory model. It also records the access activity.
    logic [31:0] mem [256];
    logic        mem_clr;
    int          cyc    = 0;
    int          en_cnt = 0;
    int          wr_cnt = 0;
    int          wr_cyc = 0;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[9:2]];
        else                   mem_rdata <= 32'hdead_beef;
        if (mem_en) en_cnt <= en_cnt + 1;
        if (mem_en && mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
            wr_cyc  <= cyc;
        end
        cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic        bt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_en;
        logic        exp_wr;
        logic [31:0] exp_wdata;
        int          exp_wr_cyc;
    } vec_t;

    task automatic do_req(input vec_t v, input int idx);
        int  base, en0, wr0, lat;
        bit  done;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        check({tag, "_ready_idle"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_byte  = v.bt;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        base = cyc;
        en0  = en_cnt;
        wr0  = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat  = 0;
        done = 1'b0;
        for (int k = 1; k <= 8 && !done; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                done = 1'b1;
                lat  = k;
            end else begin
                check({tag, "_busy_ready"}, {31'h0, req_ready}, 32'h0);
            end
        end
        check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_rdata"}, resp_rdata, v.exp_rdata);
        check({tag, "_err"}, {31'h0, resp_err}, {31'h0, v.exp_err});
        check({tag, "_mem_en_cycles"}, en_cnt - en0, v.exp_en);
        check({tag, "_writes"}, wr_cnt - wr0, v.exp_wr ? 1 : 0);
        if (v.exp_wr) begin
            check({tag, "_wr_addr"}, wr_addr, {v.addr[31:2], 2'b00});
            check({tag, "_wr_data"}, wr_data, v.exp_wdata);
            check({tag, "_wr_cycle"}, wr_cyc - base, v.exp_wr_cyc);
        end
        @(negedge clk);
        check({tag, "_resp_pulse"}, {31'h0, resp_valid}, 32'h0);
        check({tag, "_ready_after"}, {31'h0, req_ready}, 32'h1);
        check({tag, "_rdata_hold"}, resp_rdata, v.exp_rdata);
    endtask

    vec_t vecs [20];

    initial begin
        int base, en0, wr0, resp_seen;

        //            we    bt    addr         wdata         rdata         err   lat en wr    wdata         wcyc
        vecs[0]  = '{1'b1, 1'b0, 32'h40, 32'h1234_5678, 32'h0,         1'b0, 2, 1, 1'b1, 32'h1234_5678, 1};
        vecs[1]  = '{1'b0, 1'b0, 32'h40, 32'h0,         32'h1234_5678, 1'b0, 3, 1, 1'b0, 32'h0,         0};
        vecs[2]  = '{1'b1, 1'b0, 32'h40, 32'h7890_1234, 32'h0,         1'b0, 2, 1, 1'b1, 32'h7890_1234, 1};
        vecs[3]  = '{1'b1, 1'b1, 32'h41, 32'h1234_5678, 32'h0,         1'b0, 4, 2, 1'b1, 32'h7890_7834, 3};
        vecs[4]  = '{1'b1, 1'b0, 32'h40, 32'h7890_1234, 32'h0,         1'b0, 2, 1, 1'b1, 32'h7890_1234, 1};
        vecs[5]  = '{1'b0, 1'b1, 32'h40, 32'h0,         32'h34,        1'b0, 3, 1, 1'b0, 32'h0,         0};
        vecs[6]  = '{1'b0, 1'b1, 32'h41, 32'h0,         32'h12,        1'b0, 3, 1, 1'b0, 32'h0,         0};
        vecs[7]  = '{1'b0, 1'b1, 32'h42, 32'h0,         32'h90,        1'b0, 3, 1, 1'b0, 32'h0,         0};
        vecs[8]  = '{1'b0, 1'b1, 32'h43, 32'h0,         32'h78,        1'b0, 3, 1, 1'b0, 32'h0,         0};
        vecs[9]  = '{1'b0, 1'b0, 32'h42, 32'h0,         32'h0,         1'b1, 1, 0, 1'b0, 32'h0,         0};
        vecs[10] = '{1'b1, 1'b0, 32'h41, 32'hffff_ffff, 32'h0,         1'b1, 1, 0, 1'b0, 32'h0,         0};
        vecs[11] = '{1'b0, 1'b0, 32'h40, 32'h0,         32'h7890_1234, 1'b0, 3, 1, 1'b0, 32'h0,         0};
        vecs[12] = '{1'b1, 1'b1, 32'h43, 32'h0000_00ab, 32'h0,         1'b0, 4, 2, 1'b1, 32'hab90_1234, 3};
        vecs[13] = '{1'b0, 1'b1, 32'h43, 32'h0,         32'hab,        1'b0, 3, 1, 1'b0, 32'h0,         0};
        vecs[14] = '{1'b1, 1'b1, 32'h80, 32'h5555_55cd, 32'h0,         1'b0, 4, 2, 1'b1, 32'h0000_00cd, 3};
        vecs[15] = '{1'b0, 1'b0, 32'h80, 32'h0,         32'h0000_00cd, 1'b0, 3, 1, 1'b0, 32'h0,         0};
        vecs[16] = '{1'b0, 1'b1, 32'h82, 32'h0,         32'h0,         1'b0, 3, 1, 1'b0, 32'h0,         0};
        vecs[17] = '{1'b1, 1'b0, 32'h60, 32'h1122_3344, 32'h0,         1'b0, 2, 1, 1'b1, 32'h1122_3344, 1};
        vecs[18] = '{1'b1, 1'b0, 32'h50, 32'hcafe_f00d, 32'h0,         1'b0, 2, 1, 1'b1, 32'hcafe_f00d, 1};
        vecs[19] = '{1'b1, 1'b0, 32'h70, 32'ha5a5_a5a5, 32'h0,         1'b0, 2, 1, 1'b1, 32'ha5a5_a5a5, 1};

        reset     = 1'b1;
        mem_clr   = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", {31'h0, resp_err}, 32'h0);
        check("rst_mem_en", {31'h0, mem_en}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        reset   = 1'b0;
        mem_clr = 1'b0;

        for (int i = 0; i < 20; i++) do_req(vecs[i], i);

        // Busy window: hold req_valid through a byte store while wiggling the request.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_byte  = 1'b1;
        req_addr  = 32'h62;
        req_wdata = 32'h0000_0055;
        base = cyc;
        en0  = en_cnt;
        wr0  = wr_cnt;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("busy_ready_c%0d", k), {31'h0, req_ready}, 32'h0);
            check($sformatf("busy_resp_c%0d", k), {31'h0, resp_valid}, (k == 4) ? 32'h1 : 32'h0);
            req_we    = (k < 4);
            req_byte  = 1'b0;
            req_addr  = (k < 4) ? 32'h44 + 32'(4 * k) : 32'h50;
            req_wdata = 32'hffff_0000 + 32'(k);
        end
        check("busy_resp_err", {31'h0, resp_err}, 32'h0);
        check("busy_writes", wr_cnt - wr0, 1);
        check("busy_wr_addr", wr_addr, 32'h60);
        check("busy_wr_data", wr_data, 32'h1155_3344);
        check("busy_wr_cycle", wr_cyc - base, 3);
        @(negedge clk);
        check("b2b_ready_c5", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b_mem_en_c6", {31'h0, mem_en}, 32'h1);
        check("b2b_mem_we_c6", {31'h0, mem_we}, 32'h0);
        check("b2b_mem_addr_c6", mem_addr, 32'h50);
        @(negedge clk);
        check("b2b_resp_c7", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        check("b2b_resp_c8", {31'h0, resp_valid}, 32'h1);
        check("b2b_rdata", resp_rdata, 32'hcafe_f00d);
        check("b2b_total_en", en_cnt - en0, 3);

        // Reset during RCAP of a byte store, then hold reset with a request pending.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_byte  = 1'b1;
        req_addr  = 32'h71;
        req_wdata = 32'h0000_003c;
        wr0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmid_rd_en", {31'h0, mem_en}, 32'h1);
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'h70;
        @(negedge clk);
        check("rmid_ready", {31'h0, req_ready}, 32'h1);
        check("rmid_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rmid_rdata", resp_rdata, 32'h0);
        check("rmid_err", {31'h0, resp_err}, 32'h0);
        check("rmid_mem_en", {31'h0, mem_en}, 32'h0);
        check("rmid_mem_we", {31'h0, mem_we}, 32'h0);
        check("rmid_mem_addr", mem_addr, 32'h0);
        check("rmid_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        check("rheld_no_accept_ready", {31'h0, req_ready}, 32'h1);
        check("rheld_no_accept_en", {31'h0, mem_en}, 32'h0);
        reset     = 1'b0;
        req_valid = 1'b0;
        resp_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        check("rmid_no_resp", resp_seen, 0);
        check("rmid_no_write", wr_cnt - wr0, 0);
        do_req('{1'b0, 1'b0, 32'h70, 32'h0, 32'ha5a5_a5a5, 1'b0, 3, 1, 1'b0, 32'h0, 0}, 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
